// File: rtl/shift_reg_ctrl.sv
// ============================================================================
// shift_reg_ctrl - command sequencer (load, N shifts, done) for a 4-bit
// universal shift register; define SHIFT_CTRL_ROTATE_EN for rotate feedback.
// Rev 1.0
// ============================================================================
`default_nettype none

module shift_reg_ctrl #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Cmd_Valid,
  output logic             Cmd_Ready,
  input  logic [3:0]       Cmd_Data,
  input  logic             Cmd_Dir,
  input  logic [CNT_W-1:0] Cmd_Len,
  input  logic             Cmd_Fill,
`ifdef SHIFT_CTRL_ROTATE_EN
  input  logic             Fb_MSB,
  input  logic             Fb_LSB,
`endif
  output logic             s1,
  output logic             s0,
  output logic [3:0]       Data_In,
  output logic             MSB_In,
  output logic             LSB_In,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_zero = '0;
  localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] len_q,   len_d;
  logic [3:0]       data_q,  data_d;
  logic             dir_q,   dir_d;
  logic             fill_q,  fill_d;
  logic             rdy_en_q, rdy_en_d;
  logic [1:0]       mode;
  logic             fill_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= c_cnt_zero;
      len_q    <= c_cnt_zero;
      data_q   <= 4'b0000;
      dir_q    <= 1'b0;
      fill_q   <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      data_q   <= data_d;
      dir_q    <= dir_d;
      fill_q   <= fill_d;
      rdy_en_q <= rdy_en_d;
    end
  end

  // Serial fill source: captured fill bit, or the far end of the register when rotating.
`ifdef SHIFT_CTRL_ROTATE_EN
  assign fill_bit = dir_q ? Fb_MSB : Fb_LSB;
`else
  assign fill_bit = fill_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    data_d    = data_q;
    dir_d     = dir_q;
    fill_d    = fill_q;
    rdy_en_d  = 1'b1;
    mode      = 2'b00;
    Cmd_Ready = 1'b0;
    Data_In   = 4'b0000;
    MSB_In    = 1'b0;
    LSB_In    = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // rdy_en_q keeps Cmd_Ready low until the first edge after reset release.
        Cmd_Ready = rdy_en_q;
        if (Cmd_Valid && rdy_en_q) begin
          data_d  = Cmd_Data;
          dir_d   = Cmd_Dir;
          len_d   = Cmd_Len;
          fill_d  = Cmd_Fill;
          cnt_d   = Cmd_Len;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        Busy    = 1'b1;
        mode    = 2'b11;
        Data_In = data_q;
        state_d = (len_q != c_cnt_zero) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        Busy = 1'b1;
        if (dir_q) begin
          mode   = 2'b10;
          LSB_In = fill_bit;
        end else begin
          mode   = 2'b01;
          MSB_In = fill_bit;
        end
        if (cnt_q <= c_cnt_one) begin
          cnt_d   = c_cnt_zero;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - c_cnt_one;
        end
      end
      ST_DONE: begin
        Busy    = 1'b1;
        Done    = 1'b1;
        cnt_d   = c_cnt_zero;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign s1 = mode[1];
  assign s0 = mode[0];

endmodule

`default_nettype wire
